mul_div_unit: RTL and testbench

- Iterative MIPS multiply/divide unit that consumes AluA/AluB from the ALU input adapter in the execute stage, in parallel with the ALU.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and owns the architectural HI/LO registers, which MTHI/MTLO write and MFHI/MFLO read.
- Raises Busy so hazard control stalls any dependent HI/LO access.

---
 rtl/mul_div_unit_pkg.sv | 26 ++
 rtl/mdu_datapath.sv | 75 +++++++
 rtl/mul_div_unit.sv | 200 ++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
//============================================================================
// mul_div_unit_pkg : shared encodings for the multiply/divide unit
// Revision: 1.0
//============================================================================
`default_nettype none

package mul_div_unit_pkg;

  localparam int DATA_BITS_DEF = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

endpackage

`default_nettype wire

// File: rtl/mdu_datapath.sv
//============================================================================
// mdu_datapath : one radix-2 shift-add or restoring-divide step per cycle
// Revision: 1.0
//============================================================================
`default_nettype none

module mdu_datapath
  import mul_div_unit_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic                 i_is_div,
  input  logic [DATA_BITS-1:0] i_sh_init,
  input  logic [DATA_BITS-1:0] i_opd_init,
  output logic [DATA_BITS-1:0] o_hi,
  output logic [DATA_BITS-1:0] o_lo
);

  logic [DATA_BITS:0]   acc_q, acc_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] opd_q, opd_d;
  logic [DATA_BITS:0]   sum;
  logic [DATA_BITS:0]   shifted;
  logic [DATA_BITS+1:0] diff;

  always_comb begin
    acc_d   = acc_q;
    sh_d    = sh_q;
    opd_d   = opd_q;
    sum     = acc_q + (sh_q[0] ? {1'b0, opd_q} : '0);
    shifted = {acc_q[DATA_BITS-1:0], sh_q[DATA_BITS-1]};
    diff    = {1'b0, shifted} - {2'b00, opd_q};
    if (i_load) begin
      acc_d = '0;
      sh_d  = i_sh_init;
      opd_d = i_opd_init;
    end else if (i_step) begin
      if (i_is_div) begin
        // Restoring divide: keep the trial subtraction only when it did not borrow.
        if (!diff[DATA_BITS+1]) begin
          acc_d = diff[DATA_BITS:0];
          sh_d  = {sh_q[DATA_BITS-2:0], 1'b1};
        end else begin
          acc_d = shifted;
          sh_d  = {sh_q[DATA_BITS-2:0], 1'b0};
        end
      end else begin
        acc_d = {1'b0, sum[DATA_BITS:1]};
        sh_d  = {sum[0], sh_q[DATA_BITS-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sh_q  <= '0;
      opd_q <= '0;
    end else begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      opd_q <= opd_d;
    end
  end

  assign o_hi = acc_q[DATA_BITS-1:0];
  assign o_lo = sh_q;

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
//============================================================================
// mul_div_unit : iterative MIPS MULT/MULTU/DIV/DIVU with HI/LO registers.
// Optional MDU_FAST_MUL_EN selects a single-cycle combinational multiply.
// Revision: 1.0
//============================================================================
`default_nettype none

module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [DATA_BITS-1:0] AluA,
  input  logic [DATA_BITS-1:0] AluB,
  input  logic [1:0]           Op,
  input  logic                 Start,
  input  logic                 Flush,
  input  logic                 MthiWe,
  input  logic                 MtloWe,
  input  logic [DATA_BITS-1:0] WriteData,
  output logic [DATA_BITS-1:0] Hi,
  output logic [DATA_BITS-1:0] Lo,
  output logic                 Busy,
  output logic                 Done
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  mdu_state_e           state_q, state_d;
  mdu_op_e              op_q, op_d;
  logic [DATA_BITS-1:0] a_q, a_d;
  logic                 neg_a_q, neg_a_d;
  logic                 neg_b_q, neg_b_d;
  logic                 divz_q, divz_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] hi_q, hi_d;
  logic [DATA_BITS-1:0] lo_q, lo_d;
  logic                 done_q, done_d;

  mdu_op_e              op_in;
  logic                 in_signed, in_is_div, in_neg_a, in_neg_b, accept;
  logic [DATA_BITS-1:0] mag_a, mag_b;
  logic                 op_is_div;
  logic [DATA_BITS-1:0] dp_hi, dp_lo;
  logic [2*DATA_BITS-1:0] prod_mag, prod;
  logic [DATA_BITS-1:0] quo, rem, res_hi, res_lo;

  always_comb begin
    op_in     = mdu_op_e'(Op);
    in_signed = (op_in == MDU_MULT) || (op_in == MDU_DIV);
    in_is_div = (op_in == MDU_DIV) || (op_in == MDU_DIVU);
    in_neg_a  = in_signed & AluA[DATA_BITS-1];
    in_neg_b  = in_signed & AluB[DATA_BITS-1];
    mag_a     = in_neg_a ? -AluA : AluA;
    mag_b     = in_neg_b ? -AluB : AluB;
    accept    = (state_q == IDLE) && Start && !Flush;
    op_is_div = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
  end

  // Datapath shifts the multiplier or dividend through sh; opd holds the other operand.
  mdu_datapath #(.DATA_BITS(DATA_BITS)) u_datapath (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .i_load     (accept),
    .i_step     ((state_q == CALC) && !Flush),
    .i_is_div   (op_is_div),
    .i_sh_init  (in_is_div ? mag_a : mag_b),
    .i_opd_init (in_is_div ? mag_b : mag_a),
    .o_hi       (dp_hi),
    .o_lo       (dp_lo)
  );

`ifdef MDU_FAST_MUL_EN
  logic [DATA_BITS-1:0] fast_a_q, fast_a_d;
  logic [DATA_BITS-1:0] fast_b_q, fast_b_d;

  always_comb begin
    fast_a_d = accept ? mag_a : fast_a_q;
    fast_b_d = accept ? mag_b : fast_b_q;
    prod_mag = {{DATA_BITS{1'b0}}, fast_a_q} * {{DATA_BITS{1'b0}}, fast_b_q};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fast_a_q <= '0;
      fast_b_q <= '0;
    end else begin
      fast_a_q <= fast_a_d;
      fast_b_q <= fast_b_d;
    end
  end
`else
  always_comb begin
    prod_mag = {dp_hi, dp_lo};
  end
`endif

  always_comb begin
    prod = (neg_a_q ^ neg_b_q) ? -prod_mag : prod_mag;
    quo  = (neg_a_q ^ neg_b_q) ? -dp_lo : dp_lo;
    rem  = neg_a_q ? -dp_hi : dp_hi;
    if (!op_is_div) begin
      res_hi = prod[2*DATA_BITS-1:DATA_BITS];
      res_lo = prod[DATA_BITS-1:0];
    end else if (divz_q) begin
      // Divide by zero returns the raw dividend, bypassing sign correction.
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    divz_d  = divz_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MthiWe) hi_d = WriteData;
        if (MtloWe) lo_d = WriteData;
        if (accept) begin
          op_d    = op_in;
          a_d     = AluA;
          neg_a_d = in_neg_a;
          neg_b_d = in_neg_b;
          divz_d  = (AluB == '0);
          cnt_d   = '0;
`ifdef MDU_FAST_MUL_EN
          state_d = in_is_div ? CALC : FIX;
`else
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        if (Flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_BITS - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!Flush) begin
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      op_q    <= MDU_MULT;
      a_q     <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      divz_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      divz_q  <= divz_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign Busy = (state_q != IDLE);
  assign Done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
//============================================================================
// tb_mul_div_unit : scoreboard bench for mul_div_unit
// Revision: 1.0
//============================================================================
`default_nettype none

module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_a, alu_b, write_data;
  logic [1:0]  op;
  logic        start, flush, mthi_we, mtlo_we;
  logic [31:0] hi, lo;
  logic        busy, done;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb_q[$];
  logic [63:0] exp_v;

  always #5 clk = ~clk;

  mul_div_unit #(.DATA_BITS(32)) dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .AluA      (alu_a),
    .AluB      (alu_b),
    .Op        (op),
    .Start     (start),
    .Flush     (flush),
    .MthiWe    (mthi_we),
    .MtloWe    (mtlo_we),
    .WriteData (write_data),
    .Hi        (hi),
    .Lo        (lo),
    .Busy      (busy),
    .Done      (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] m_op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    case (m_op)
      2'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      2'd1: return {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (m_op == 2'd2) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
        end else begin
          sa = longint'({32'd0, a});
          sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Scoreboard: every Done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        exp_v = sb_q.pop_front();
        check("result", {hi, lo}, exp_v);
      end
    end
  end

  task automatic launch(input logic [1:0] l_op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = l_op;
    alu_a = a;
    alu_b = b;
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom);
    alu_a = $urandom;
    alu_b = $urandom;
  endtask

  task automatic run_op(input logic [1:0] r_op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int k, busy_cnt, lat;
    lat = r_op[1] ? DIV_LAT : MUL_LAT;
    sb_q.push_back(exp);
    launch(r_op, a, b);
    k = 1;
    busy_cnt = 0;
    while (!done && k <= 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      k++;
    end
    check("latency", 64'(k), 64'(lat + 1));
    check("busy_cycles", 64'(busy_cnt), 64'(lat));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r_op;
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    alu_a = '0; alu_b = '0; op = '0; write_data = '0;
    start = 1'b0; flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, chained so each Start lands in the previous Done cycle.
    run_op(2'd0, 32'hFFFF_FFFD, 32'd5,          64'hFFFF_FFFF_FFFF_FFF1);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001);
    run_op(2'd3, 32'd100,       32'd7,          64'h0000_0002_0000_000E);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2,          64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF,  64'h0000_0000_8000_0000);
    run_op(2'd3, 32'h0000_1234, 32'd0,          64'h0000_1234_FFFF_FFFF);
    run_op(2'd2, 32'hFFFF_FFFB, 32'd0,          64'hFFFF_FFFB_FFFF_FFFF);
    run_op(2'd0, 32'd7,         32'd6,          64'h0000_0000_0000_002A);
    run_op(2'd2, 32'd7,         32'hFFFF_FFFE,  64'h0000_0001_FFFF_FFFD);

    for (int i = 0; i < 6; i++) begin
      r_op = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i == 2) rb = 32'd0;
      else if (r_op[1] && i[0]) rb = rb >> 20;
      run_op(r_op, ra, rb, model(r_op, ra, rb));
    end

    // MTHI/MTLO in IDLE, then a flushed MULT with ignored traffic while busy.
    mthi_we = 1'b1; mtlo_we = 1'b1; write_data = 32'hAAAA_5555;
    @(negedge clk);
    mthi_we = 1'b0; mtlo_we = 1'b0;
    check("mthi_idle", 64'(hi), 64'hAAAA_5555);
    check("mtlo_idle", 64'(lo), 64'hAAAA_5555);
    mtlo_we = 1'b1; write_data = 32'h0BAD_F00D;
    @(negedge clk);
    mtlo_we = 1'b0;
    check("mtlo_idle2", 64'(lo), 64'h0BAD_F00D);

    launch(2'd0, 32'd2, 32'd3);
    repeat (2) @(negedge clk);
    start = 1'b1; op = 2'd3; alu_a = 32'd100; alu_b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    mtlo_we = 1'b1; write_data = 32'h1234_5678;
    @(negedge clk);
    mtlo_we = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_before_flush", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_hi", 64'(hi), 64'hAAAA_5555);
    check("flush_lo", 64'(lo), 64'h0BAD_F00D);
    repeat (40) @(negedge clk);
    check("flush_no_done_lo", 64'(lo), 64'h0BAD_F00D);

    // Flush together with Start in IDLE suppresses the launch.
    start = 1'b1; flush = 1'b1; op = 2'd1; alu_a = 32'd9; alu_b = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {63'd0, busy}, 64'd0);

    // Asynchronous reset in the middle of a divide.
    launch(2'd2, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_hi", 64'(hi), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(2'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E);

    @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
